// File: rtl/dncnt_timer_ctrl.sv
// ============================================================================
// Module     : dncnt_timer_ctrl
// Description: One-shot interval timer built around an N-bit down-counter.
//              It loads a start value, decrements on prescaled ticks, and
//              supports pause/resume, abort and a done/ack handshake.
//              Optional macro AUTO_RELOAD_EN: the count reloads on expiry and
//              done gives a one-cycle pulse.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module dncnt_timer_ctrl #(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         pause,
  input  logic         abort,
  input  logic         ack,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_PTOP = c_PW'(PRESCALE - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [N-1:0]    r_count;
  logic [c_PW-1:0] r_pcnt;
  logic            r_busy;
  logic            r_done;
`ifdef AUTO_RELOAD_EN
  logic [N-1:0]    r_reload;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_count  <= '0;
      r_pcnt   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else if (abort) begin
      r_state <= c_IDLE;
      r_count <= '0;
      r_pcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_count  <= load_val;
            r_pcnt   <= '0;
`ifdef AUTO_RELOAD_EN
            r_reload <= load_val;
`endif
            // A zero load expires immediately without spending a RUN cycle.
            if (load_val == '0) begin
              r_state <= c_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= c_RUN;
              r_busy  <= 1'b1;
            end
          end
        end

        c_RUN: begin
          r_done <= 1'b0;
          if (pause) begin
            r_state <= c_HOLD;
          end else if (r_pcnt == c_PTOP) begin
            r_pcnt <= '0;
            if (r_count == N'(1)) begin
`ifdef AUTO_RELOAD_EN
              // Reload value is nonzero here: a zero load never reaches RUN.
              r_count <= r_reload;
              r_done  <= 1'b1;
`else
              r_count <= '0;
              r_state <= c_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else if (r_count != '0) begin
              r_count <= r_count - N'(1);
            end
          end else begin
            r_pcnt <= r_pcnt + c_PW'(1);
          end
        end

        c_HOLD: begin
          r_done <= 1'b0;
          if (!pause) begin
            r_state <= c_RUN;
          end
        end

        c_DONE: begin
          r_count <= '0;
          if (ack) begin
            r_state <= c_IDLE;
            r_done  <= 1'b0;
          end
        end

        default: begin
          r_state <= c_IDLE;
          r_count <= '0;
          r_pcnt  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dncnt_timer_ctrl.sv
// ============================================================================
// Module     : tb_dncnt_timer_ctrl
// Description: Scoreboard bench for dncnt_timer_ctrl (PRESCALE=1 and 3 units).
//              It honours the AUTO_RELOAD_EN macro if that macro is defined.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dncnt_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, start3, pause, abort, ack;
  logic [3:0] load_val;
  logic [3:0] count0, count1;
  logic       busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  dncnt_timer_ctrl #(.N(4), .PRESCALE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .pause(pause),
    .abort(abort), .ack(ack), .count(count0), .busy(busy0), .done(done0)
  );

  dncnt_timer_ctrl #(.N(4), .PRESCALE(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start3), .load_val(load_val), .pause(pause),
    .abort(abort), .ack(ack), .count(count1), .busy(busy1), .done(done1)
  );

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   cycle   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
      e = sbq.pop_front();
      n_tests++;
      act = (e.sel == 1) ? {count1, busy1, done1} : {count0, busy0, done0};
      if (e.cyc < cycle) begin
        n_fail++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.nm, e.cyc, cycle);
      end else if (act !== {e.cnt, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s: dut%0d count/busy/done = %0d/%b/%b, required %0d/%b/%b",
                 e.nm, e.sel, act[5:2], act[1], act[0], e.cnt, e.busy, e.done);
      end
    end
  end

  task automatic drv(input logic r, input logic s, input logic [3:0] lv,
                     input logic p, input logic a, input logic k, input logic s3);
    @(negedge clk);
    #1;
    rst = r; start = s; load_val = lv; pause = p; abort = a; ack = k; start3 = s3;
  endtask

  task automatic chk(input int sel, input logic [3:0] c, input logic b,
                     input logic d, input string nm);
    exp_t e;
    e.cyc = cycle + 1; e.sel = sel; e.cnt = c; e.busy = b; e.done = d; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic idle();
    drv(0, 0, 4'd0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0; pause = 1'b0;
    abort = 1'b0; ack = 1'b0; load_val = 4'd0;

    // Reset held two cycles, then released.
    drv(1, 0, 4'd0, 0, 0, 0, 0);
    drv(1, 1, 4'd7, 0, 0, 0, 1); chk(0, 4'd0, 0, 0, "reset0"); chk(1, 4'd0, 0, 0, "reset1");
    idle();                      chk(0, 4'd0, 0, 0, "post_reset");

    // Basic countdown from 5.
    drv(0, 1, 4'd5, 0, 0, 0, 0); chk(0, 4'd5, 1, 0, "run_load5");
    idle(); chk(0, 4'd4, 1, 0, "run_4");
    idle(); chk(0, 4'd3, 1, 0, "run_3");
    idle(); chk(0, 4'd2, 1, 0, "run_2");
    idle(); chk(0, 4'd1, 1, 0, "run_1");
`ifdef AUTO_RELOAD_EN
    idle(); chk(0, 4'd5, 1, 1, "reload_5_pulse");
    idle(); chk(0, 4'd4, 1, 0, "reload_4");
    drv(0, 0, 4'd0, 0, 1, 0, 0); chk(0, 4'd0, 0, 0, "reload_abort");
`else
    idle(); chk(0, 4'd0, 0, 1, "done_0");
    drv(0, 1, 4'd6, 0, 0, 0, 0); chk(0, 4'd0, 0, 1, "done_held_start_ignored");
    drv(0, 0, 4'd0, 0, 0, 1, 0); chk(0, 4'd0, 0, 0, "ack_idle");
`endif
    idle(); chk(0, 4'd0, 0, 0, "idle_stays");

    // Pause from 6 for three cycles, then resume.
    drv(0, 1, 4'd9, 0, 0, 0, 0); chk(0, 4'd9, 1, 0, "p_load9");
    idle(); chk(0, 4'd8, 1, 0, "p_8");
    idle(); chk(0, 4'd7, 1, 0, "p_7");
    idle(); chk(0, 4'd6, 1, 0, "p_6");
    drv(0, 0, 4'd0, 1, 0, 0, 0); chk(0, 4'd6, 1, 0, "hold_a");
    drv(0, 0, 4'd0, 1, 0, 0, 0); chk(0, 4'd6, 1, 0, "hold_b");
    drv(0, 0, 4'd0, 1, 0, 0, 0); chk(0, 4'd6, 1, 0, "hold_c");
    idle(); chk(0, 4'd6, 1, 0, "resume_edge");
    idle(); chk(0, 4'd5, 1, 0, "resume_5");
    drv(0, 0, 4'd0, 0, 1, 0, 0); chk(0, 4'd0, 0, 0, "p_abort");

    // Abort at count 3, then abort together with pause.
    drv(0, 1, 4'd5, 0, 0, 0, 0); chk(0, 4'd5, 1, 0, "a_load5");
    idle(); chk(0, 4'd4, 1, 0, "a_4");
    idle(); chk(0, 4'd3, 1, 0, "a_3");
    drv(0, 0, 4'd0, 0, 1, 0, 0); chk(0, 4'd0, 0, 0, "abort_run");
    idle(); chk(0, 4'd0, 0, 0, "abort_stays_idle");
    drv(0, 1, 4'd7, 0, 0, 0, 0); chk(0, 4'd7, 1, 0, "a_load7");
    drv(0, 0, 4'd0, 1, 1, 0, 0); chk(0, 4'd0, 0, 0, "abort_pause");
    idle(); chk(0, 4'd0, 0, 0, "abort_pause_idle");

    // Zero load goes straight to DONE; start+ack leaves it without restarting.
    drv(0, 1, 4'd0, 0, 0, 0, 0); chk(0, 4'd0, 0, 1, "zero_done");
    drv(0, 0, 4'd0, 1, 0, 0, 0); chk(0, 4'd0, 0, 1, "zero_pause_noeffect");
    drv(0, 1, 4'd4, 0, 0, 1, 0); chk(0, 4'd0, 0, 0, "start_ack_idle");
    idle(); chk(0, 4'd0, 0, 0, "no_restart");
    drv(0, 1, 4'd0, 0, 0, 0, 0); chk(0, 4'd0, 0, 1, "zero_done2");
    drv(0, 0, 4'd0, 0, 1, 0, 0); chk(0, 4'd0, 0, 0, "abort_done");

    // PRESCALE=3 unit, load 2.
    drv(0, 0, 4'd2, 0, 0, 0, 1); chk(1, 4'd2, 1, 0, "ps_load2");
    idle(); chk(1, 4'd2, 1, 0, "ps_e1");
    idle(); chk(1, 4'd2, 1, 0, "ps_e2");
    idle(); chk(1, 4'd1, 1, 0, "ps_e3");
    idle(); chk(1, 4'd1, 1, 0, "ps_e4");
    idle(); chk(1, 4'd1, 1, 0, "ps_e5");
`ifdef AUTO_RELOAD_EN
    idle(); chk(1, 4'd2, 1, 1, "ps_wrap1");
    idle(); chk(1, 4'd2, 1, 0, "ps_e7");
    idle(); chk(1, 4'd2, 1, 0, "ps_e8");
    idle(); chk(1, 4'd1, 1, 0, "ps_e9");
    idle(); chk(1, 4'd1, 1, 0, "ps_e10");
    idle(); chk(1, 4'd1, 1, 0, "ps_e11");
    idle(); chk(1, 4'd2, 1, 1, "ps_wrap2");
    drv(0, 0, 4'd0, 0, 1, 0, 0); chk(1, 4'd0, 0, 0, "ps_abort");
`else
    idle(); chk(1, 4'd0, 0, 1, "ps_done");
    idle(); chk(1, 4'd0, 0, 1, "ps_done_held");
    drv(0, 0, 4'd0, 0, 0, 1, 0); chk(1, 4'd0, 0, 0, "ps_ack");
`endif

    repeat (3) @(negedge clk);
    #2;
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation never checked (due cycle %0d)", e.nm, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
